// File: rtl/shreg_pkg.sv
// Shared mode encodings and width helper for the universal shift register.
// Optional rotate support is enabled with SHREG_ROTATE_EN.
package shreg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shreg_frame_cnt.sv
// Frame counter: counts shifts, wraps at WIDTH and
// raises a registered one-cycle frame_done pulse.
module shreg_frame_cnt
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             shift,
  input  logic             load,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (!en) begin
      r_done <= 1'b0;
    end else if (load) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (shift) begin
      // wrap instead of reaching WIDTH
      r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
      r_done <= w_last;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign cnt  = r_cnt;
  assign done = r_done;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift left/right, parallel load.
// Define SHREG_ROTATE_EN to add the rot input (rotate instead of serial in).
module shift_reg_univ
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             si_l,
  input  logic             si_r,
  input  logic [WIDTH-1:0] pi,
`ifdef SHREG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             so_l,
  output logic             so_r,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_shift;
  logic             w_load;
  logic             w_in_l;
  logic             w_in_r;

`ifdef SHREG_ROTATE_EN
  assign w_in_l = rot ? r_q[WIDTH-1] : si_l;
  assign w_in_r = rot ? r_q[0] : si_r;
`else
  assign w_in_l = si_l;
  assign w_in_r = si_r;
`endif

  always_comb begin
    w_next  = r_q;
    w_shift = 1'b0;
    w_load  = 1'b0;
    unique case (1'b1)
      (mode == MODE_HOLD): ;
      (mode == MODE_SHL): begin
        w_next  = {r_q[WIDTH-2:0], w_in_l};
        w_shift = 1'b1;
      end
      (mode == MODE_SHR): begin
        w_next  = {w_in_r, r_q[WIDTH-1:1]};
        w_shift = 1'b1;
      end
      (mode == MODE_LOAD): begin
        w_next = pi;
        w_load = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= w_next;
    end
  end

  shreg_frame_cnt #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_frame_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .shift(w_shift),
    .load (w_load),
    .cnt  (shift_cnt),
    .done (frame_done)
  );

  assign q    = r_q;
  assign so_l = r_q[WIDTH-1];
  assign so_r = r_q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ (WIDTH=8), directed plan
// followed by randomized traffic against an arithmetic model.
module tb_shift_reg_univ;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic          si_l;
  logic          si_r;
  logic [W-1:0]  pi;
  logic [W-1:0]  q;
  logic          so_l;
  logic          so_r;
  logic [CW-1:0] shift_cnt;
  logic          frame_done;
`ifdef SHREG_ROTATE_EN
  logic          rot;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    int q;
    int cnt;
    bit done;
  } exp_t;

  exp_t sb[$];

  int m_q   = 0;
  int m_cnt = 0;
  bit m_done = 0;

  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .si_l      (si_l),
    .si_r      (si_r),
    .pi        (pi),
`ifdef SHREG_ROTATE_EN
    .rot       (rot),
`endif
    .q         (q),
    .so_l      (so_l),
    .so_r      (so_r),
    .shift_cnt (shift_cnt),
    .frame_done(frame_done)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // model: one frame ends every W shifts
  task automatic count_shift();
    m_cnt++;
    if (m_cnt == W) begin
      m_cnt  = 0;
      m_done = 1;
    end else begin
      m_done = 0;
    end
  endtask

  task automatic step(input bit r, input bit e,
                      input bit [1:0] md,
                      input bit sl, input bit sr,
                      input bit [W-1:0] p,
                      input bit rt = 0);
    int msk;
    int inb;
    bit rot_on;
    exp_t x;
    @(negedge clk);
    rst  = r;
    en   = e;
    mode = md;
    si_l = sl;
    si_r = sr;
    pi   = p;
`ifdef SHREG_ROTATE_EN
    rot    = rt;
    rot_on = rt;
`else
    rot_on = 0;
`endif
    msk = (1 << W) - 1;
    if (!r) begin
      m_q = 0; m_cnt = 0; m_done = 0;
    end else if (!e) begin
      m_done = 0;
    end else begin
      case (md)
        2'd0: m_done = 0;
        2'd1: begin
          inb = rot_on ? (m_q >> (W - 1)) & 1 : int'(sl);
          m_q = ((m_q << 1) | inb) & msk;
          count_shift();
        end
        2'd2: begin
          inb = rot_on ? m_q & 1 : int'(sr);
          m_q = (m_q >> 1) | (inb << (W - 1));
          count_shift();
        end
        default: begin
          m_q = int'(p); m_cnt = 0; m_done = 0;
        end
      endcase
    end
    x.q = m_q; x.cnt = m_cnt; x.done = m_done;
    sb.push_back(x);
  endtask

  task automatic spot(input string name,
                      input int eq, input int ec,
                      input bit ed);
    @(posedge clk);
    #2;
    check({name, ".q"}, q, eq);
    check({name, ".cnt"}, shift_cnt, ec);
    check({name, ".done"}, frame_done, ed);
  endtask

  // monitor: every cycle with a pending expectation is compared
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("sb.q", q, x.q);
        check("sb.so_l", so_l, (x.q >> (W - 1)) & 1);
        check("sb.so_r", so_r, x.q & 1);
        check("sb.cnt", shift_cnt, x.cnt);
        check("sb.done", frame_done, x.done);
      end
    end
  end

  initial begin
    bit [7:0] sipo;
    rst = 0; en = 1; mode = 2'b11;
    si_l = 0; si_r = 0; pi = 8'hFF;
`ifdef SHREG_ROTATE_EN
    rot = 0;
`endif
    sipo = 8'b1011_0010;

    step(0, 1, 3, 0, 0, 8'hFF);
    step(0, 1, 3, 0, 0, 8'hFF);
    spot("reset", 0, 0, 0);
    check("reset.so_l", so_l, 0);
    check("reset.so_r", so_r, 0);

    for (int i = 7; i >= 0; i--)
      step(1, 1, 1, sipo[i], 0, 0);
    spot("sipo", 8'hB2, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    spot("sipo.after", 8'hB2, 0, 0);

    step(1, 1, 3, 0, 0, 8'hA5);
    for (int i = 0; i < 8; i++)
      step(1, 1, 2, 0, 0, 0);
    spot("piso", 0, 0, 1);

    step(1, 1, 3, 0, 0, 8'h3C);
    for (int i = 0; i < 3; i++)
      step(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(1, 0, 1, 1, 0, 0);
    spot("engate", 8'hE0, 3, 0);
    for (int i = 0; i < 5; i++)
      step(1, 1, 1, 0, 0, 0);
    spot("engate.end", 0, 0, 1);

    for (int i = 0; i < 7; i++)
      step(1, 1, 1, 1, 0, 0);
    step(1, 1, 3, 0, 0, 8'h5A);
    spot("ldwrap", 8'h5A, 0, 0);

    for (int i = 0; i < 4; i++)
      step(1, 1, 2, 0, 1, 0);
    step(0, 1, 2, 0, 1, 0);
    spot("rstmid", 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step(1, 1, 1, 1, 0, 0);
    spot("rstmid.frame", 8'hFF, 0, 1);

`ifdef SHREG_ROTATE_EN
    step(1, 1, 3, 0, 0, 8'h81);
    step(1, 1, 1, 0, 0, 0, 1);
    spot("rotl", 8'h03, 1, 0);
    step(1, 1, 3, 0, 0, 8'h81);
    step(1, 1, 2, 1, 1, 0, 1);
    spot("rotr", 8'hC0, 1, 0);
`endif

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 4) != 0,
           2'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom),
           8'($urandom),
           1'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    check("sb.drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
